pipe_retire_monitor: RTL

- Synthesizable performance and retirement monitor that sits downstream of the pipelined cpu's writeback, memory and hazard stages.
- Consumes per-cycle retire, halt, stall, flush and forwarding strobes and keeps saturating event counters.
- Detects end-of-program (halt) or a runaway program (cycle watchdog).
- Exposes counters through a registered select/readout port, so the cpu-level bench and on-board debug read identical statistics without hierarchical probing.

---
 rtl/pipe_retire_monitor.sv | 122 ++++++++++++
 1 files changed

// File: rtl/pipe_retire_monitor.sv
// Retirement/performance monitor for the pipelined cpu: saturating event counters,
// halt/watchdog detection and a registered counter readout port.
module pipe_retire_monitor #(
   parameter int CNT_W          = 32,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   input  logic             reg_we,
   input  logic             mem_we,
   input  logic             halt,
   input  logic             stall,
   input  logic             flush,
   input  logic [1:0]       ex_ex_fwd,
   input  logic [1:0]       ex_mem_fwd,
   input  logic             mem_mem_fwd,
   input  logic [2:0]       sel,
   output logic [CNT_W-1:0] rd_data,
   output logic [1:0]       state,
   output logic             done,
   output logic             timeout
);

   // state     | meaning
   // S_IDLE    | waiting for en, nothing counted
   // S_RUN     | counting every cycle, watching for halt / watchdog
   // S_HALTED  | program halted, counters frozen until clr/rst
   // S_TIMEOUT | watchdog expired, counters frozen until clr/rst
   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_RUN     = 2'd1,
      S_HALTED  = 2'd2,
      S_TIMEOUT = 2'd3
   } state_t;

   localparam int              NCNT    = 7;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT_CYCLES);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q [NCNT];
   logic [CNT_W-1:0] cnt_d [NCNT];
   logic [NCNT-1:0]  evt;
   logic [CNT_W-1:0] status_word;
   logic [CNT_W-1:0] rd_mux;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic e);
      return (e && (v != CNT_MAX)) ? v + CNT_W'(1) : v;
   endfunction

   // index order matches the readout select map
   always_comb begin
      evt    = '0;
      evt[0] = 1'b1;
      evt[1] = halt | reg_we | mem_we;
      evt[2] = stall;
      evt[3] = flush;
      evt[4] = |ex_ex_fwd;
      evt[5] = |ex_mem_fwd;
      evt[6] = mem_mem_fwd;
   end

   always_comb begin
      state_d = state_q;
      for (int i = 0; i < NCNT; i++) cnt_d[i] = cnt_q[i];
      if (clr) begin
         state_d = S_IDLE;
         for (int i = 0; i < NCNT; i++) cnt_d[i] = '0;
      end else begin
         case (state_q)
            S_IDLE: if (en) state_d = S_RUN;
            S_RUN: begin
               for (int i = 0; i < NCNT; i++) cnt_d[i] = sat_inc(cnt_q[i], evt[i]);
               if (halt)                    state_d = S_HALTED;
               else if (cnt_d[0] == TO_VAL) state_d = S_TIMEOUT;
            end
            default: ;
         endcase
      end
   end

   assign state   = state_q;
   assign done    = (state_q == S_HALTED) || (state_q == S_TIMEOUT);
   assign timeout = (state_q == S_TIMEOUT);

   always_comb begin
      status_word      = '0;
      status_word[0]   = done;
      status_word[1]   = timeout;
      status_word[3:2] = state_q;
   end

   always_comb begin
      rd_mux = '0;
      case (sel)
         3'd0:    rd_mux = cnt_q[0];
         3'd1:    rd_mux = cnt_q[1];
         3'd2:    rd_mux = cnt_q[2];
         3'd3:    rd_mux = cnt_q[3];
         3'd4:    rd_mux = cnt_q[4];
         3'd5:    rd_mux = cnt_q[5];
         3'd6:    rd_mux = cnt_q[6];
         default: rd_mux = status_word;
      endcase
   end

   // readout samples the pre-update counters, so clr does not zero it on its own edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         for (int i = 0; i < NCNT; i++) cnt_q[i] <= '0;
         rd_data <= '0;
      end else begin
         state_q <= state_d;
         for (int i = 0; i < NCNT; i++) cnt_q[i] <= cnt_d[i];
         rd_data <= rd_mux;
      end
   end

endmodule
